image_write_unit: RTL and testbench
===================================

# image_write_unit

Write-side counterpart of the image read path. It accepts the equalized pixel stream from the histogram-equalization datapath over a valid/ready handshake and stores each pixel in raster order into an on-chip WIDTH×HEIGHT frame memory. A registered read port serves the VGA scan-out side. `calcDone` tells the display path that a complete equalized frame is resident.

## Interface
Parameters:
- DATA_WIDTH, 8, pixel width
- ADDR_WIDTH, 14, frame-memory address width; WIDTH*HEIGHT ≤ 2^ADDR_WIDTH is mandatory
- WIDTH, 128, pixels per row
- HEIGHT, 128, rows per frame

Ports:
- wClk  in  1  single clock for all logic
- rstN  in  1  reset, asynchronous assert, active-low
- start  in  1  one-cycle pulse that begins a frame write
- pixIn  in  DATA_WIDTH  equalized pixel
- pixValid  in  1  pixIn is valid
- pixReady  out  1  block can accept a pixel this cycle
- re  in  1  read enable
- rAddr  in  ADDR_WIDTH  read address, computed as row*WIDTH + col
- rd  out  DATA_WIDTH  read data
- busy  out  1  a frame write is in progress
- calcDone  out  1  a full frame has been written
- curX, curY  out  11 each  column and row of the next pixel to be written

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: pixReady=0, busy=0, calcDone=0. When start=1, go to RUN and clear curX and curY to 0.
- RUN: pixReady=1, busy=1.
  - A transfer happens when pixValid && pixReady. It writes mem[curY*WIDTH + curX] ← pixIn.
  - After each transfer, curX increments. When curX=WIDTH-1, curX wraps to 0 and curY increments.
  - A transfer at (WIDTH-1, HEIGHT-1) moves the FSM to DONE. curX and curY then hold at 0 and HEIGHT.
- DONE: calcDone=1, pixReady=0, busy=0. When start=1, go to RUN, clear the counters and drop calcDone.
- start during RUN is ignored. The frame continues.
- pixValid in IDLE or DONE is ignored. No write occurs and the counters do not change.
- Address arithmetic uses ADDR_WIDTH-bit unsigned values. curY*WIDTH + curX never exceeds WIDTH*HEIGHT-1.
- Read port:
  - When re=1, rd ← mem[rAddr] on the next edge.
  - If rAddr ≥ WIDTH*HEIGHT, rd ← 0.
  - When re=0, rd holds its value.
- Reset values: pixReady=0, busy=0, calcDone=0, curX=0, curY=0, rd=0. Memory contents are not reset.
- Reset asserted mid-frame: state returns to IDLE immediately and all outputs take their reset values. Pixels already written remain in memory.

## Timing
- pixReady is decoded from the registered state only. It has no combinational path from pixValid.
- Write latency: a pixel accepted on edge N is readable by a read issued on edge N+1 or later. Same-edge collisions follow the Configuration section.
- Read latency: 1 cycle from re to rd.
- calcDone rises on the edge after the final transfer.
- start to first possible transfer: 1 cycle. pixReady is high in the cycle after the start edge.
- Throughput: one pixel per cycle, so a full frame takes WIDTH*HEIGHT cycles when pixValid is held high.

## Configuration
- IMG_WR_FWD_EN defined: if re=1, a transfer is occurring, and rAddr equals the write address in the same cycle, rd returns pixIn (new data).
- IMG_WR_FWD_EN undefined: in that same collision, rd returns the old memory contents (read-before-write).

## Structure
- Package img_pkg holds:
  - the state enum (IDLE, RUN, DONE)
  - the defaults for DATA_WIDTH, ADDR_WIDTH, WIDTH and HEIGHT
  - PIX_COUNT = WIDTH*HEIGHT
- Sub-module pixel_ram_sdp: a simple dual-port synchronous RAM with one write port and one registered read port. Forwarding logic lives in the top level under IMG_WR_FWD_EN.

## Test plan
- Reset, then start, then 16384 pixels with pixIn = addr[7:0] and pixValid held high → calcDone rises at cycle 16385. Reading rAddr=300 returns 0x2C.
- pixValid toggles every other cycle → writes occur only on valid cycles. curX/curY step correctly across the wrap from (127,0) to (0,1). The frame completes after 16384 transfers.
- start pulsed mid-frame at pixel 5000 → ignored. calcDone still asserts after pixel 16383.
- rstN asserted at pixel 100 → pixReady=0, curX=0, curY=0 immediately. After a new start, writing resumes at address 0. The data at address 50 is unchanged.
- Read rAddr=16384 with re=1 → rd=0 the next cycle. With re=0, rd holds its last value.
- Same-cycle write and read of address 42 with pixIn=0xA5 over old value 0x11 → rd=0xA5 with IMG_WR_FWD_EN defined, rd=0x11 without it.

Source files
------------

// File: rtl/img_pkg.sv
// Shared definitions for the image write unit.
//   state_t      : frame-write FSM states (IDLE, RUN, DONE)
//   *_DEF        : default geometry / width parameters
//   PIX_COUNT    : pixels per frame for the default geometry
//   COORD_WIDTH  : width of the curX / curY coordinate outputs
package img_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 14;
  localparam int WIDTH_DEF      = 128;
  localparam int HEIGHT_DEF     = 128;
  localparam int PIX_COUNT      = WIDTH_DEF * HEIGHT_DEF;
  localparam int COORD_WIDTH    = 11;

endpackage

// File: rtl/pixel_ram_sdp.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
//   clk   : clock for both ports
//   we    : write enable;  waddr / wdata : write address / data
//   re    : read enable;   raddr         : read address
//   rdata : registered read data, holds while re=0
// A same-edge read of the address being written returns the old contents.
// Callers must keep addresses below DEPTH; the memory is not reset.
module pixel_ram_sdp #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 14,
  parameter int DEPTH      = 16384
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr[IDX_W-1:0]] <= wdata;
    if (re) rdata <= mem[raddr[IDX_W-1:0]];
  end

endmodule

// File: rtl/image_write_unit.sv
// Image write unit: stores an equalized pixel stream in raster order into a
// WIDTH x HEIGHT frame memory and serves a registered read port for scan-out.
//   wClk, rstN          : clock, asynchronous active-low reset
//   start               : pulse that begins a frame write (ignored while busy)
//   pixIn, pixValid     : pixel stream input
//   pixReady            : pixel accepted this cycle when pixValid is high
//   re, rAddr, rd       : read port, 1-cycle latency, rd holds while re=0,
//                         out-of-frame addresses read as 0
//   busy, calcDone      : frame in progress / complete frame resident
//   curX, curY          : coordinates of the next pixel to be written
// Build option IMG_WR_FWD_EN: a read colliding with a same-cycle write returns
// the incoming pixel; without it the old memory contents are returned.
module image_write_unit
  import img_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int WIDTH      = WIDTH_DEF,
  parameter int HEIGHT     = HEIGHT_DEF
) (
  input  logic                   wClk,
  input  logic                   rstN,
  input  logic                   start,
  input  logic [DATA_WIDTH-1:0]  pixIn,
  input  logic                   pixValid,
  output logic                   pixReady,
  input  logic                   re,
  input  logic [ADDR_WIDTH-1:0]  rAddr,
  output logic [DATA_WIDTH-1:0]  rd,
  output logic                   busy,
  output logic                   calcDone,
  output logic [COORD_WIDTH-1:0] curX,
  output logic [COORD_WIDTH-1:0] curY
);

  localparam int PIX = WIDTH * HEIGHT;

  state_t                state;
  logic                  xfer;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] ram_rd;
  logic                  zero_p1;

  // pixReady is a registered FSM output, so a transfer never depends
  // combinationally on pixValid feeding back into ready.
  assign xfer     = pixValid && pixReady;
  assign waddr    = ADDR_WIDTH'(curY) * ADDR_WIDTH'(WIDTH) + ADDR_WIDTH'(curX);
  // Extra bit so the compare still works when PIX == 2**ADDR_WIDTH.
  assign in_range = ({1'b0, rAddr} < (ADDR_WIDTH+1)'(PIX));

  always_ff @(posedge wClk or negedge rstN) begin
    if (!rstN) begin
      state    <= IDLE;
      pixReady <= 1'b0;
      busy     <= 1'b0;
      calcDone <= 1'b0;
      curX     <= '0;
      curY     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= RUN;
            pixReady <= 1'b1;
            busy     <= 1'b1;
            calcDone <= 1'b0;
            curX     <= '0;
            curY     <= '0;
          end
        end
        RUN: begin
          if (xfer) begin
            if (curX == COORD_WIDTH'(WIDTH - 1)) begin
              curX <= '0;
              if (curY == COORD_WIDTH'(HEIGHT - 1)) begin
                // Last pixel: park the counters one row past the frame.
                state    <= DONE;
                pixReady <= 1'b0;
                busy     <= 1'b0;
                calcDone <= 1'b1;
                curY     <= COORD_WIDTH'(HEIGHT);
              end else begin
                curY <= curY + 1'b1;
              end
            end else begin
              curX <= curX + 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          pixReady <= 1'b0;
          busy     <= 1'b0;
          calcDone <= 1'b0;
        end
      endcase
    end
  end

  pixel_ram_sdp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (PIX)
  ) u_ram (
    .clk   (wClk),
    .we    (xfer),
    .waddr (waddr),
    .wdata (pixIn),
    .re    (re && in_range),
    .raddr (rAddr),
    .rdata (ram_rd)
  );

  // ---- read stage p1: select registered with the read, so rd holds when re=0
  // zero_p1 also masks the unreset RAM output register until the first read.
  always_ff @(posedge wClk or negedge rstN) begin
    if (!rstN)   zero_p1 <= 1'b1;
    else if (re) zero_p1 <= !in_range;
  end

`ifdef IMG_WR_FWD_EN
  logic                  fwd_p1;
  logic [DATA_WIDTH-1:0] fwd_data_p1;

  always_ff @(posedge wClk or negedge rstN) begin
    if (!rstN)   fwd_p1 <= 1'b0;
    else if (re) fwd_p1 <= xfer && (rAddr == waddr);
  end

  always_ff @(posedge wClk) begin
    if (re && xfer) fwd_data_p1 <= pixIn;
  end

  assign rd = zero_p1 ? '0 : (fwd_p1 ? fwd_data_p1 : ram_rd);
`else
  assign rd = zero_p1 ? '0 : ram_rd;
`endif

endmodule

// File: tb/tb_image_write_unit.sv
// Self-checking bench for image_write_unit (128x128 frame, 8-bit pixels,
// 15-bit read address so out-of-frame reads can be issued).
module tb_image_write_unit;

  localparam int DW  = 8;
  localparam int AW  = 15;
  localparam int W   = 128;
  localparam int H   = 128;
  localparam int PIX = W * H;

  logic          wClk = 1'b0;
  logic          rstN;
  logic          start;
  logic [DW-1:0] pixIn;
  logic          pixValid;
  logic          pixReady;
  logic          re;
  logic [AW-1:0] rAddr;
  logic [DW-1:0] rd;
  logic          busy;
  logic          calcDone;
  logic [10:0]   curX;
  logic [10:0]   curY;

  image_write_unit #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .WIDTH      (W),
    .HEIGHT     (H)
  ) dut (
    .wClk     (wClk),
    .rstN     (rstN),
    .start    (start),
    .pixIn    (pixIn),
    .pixValid (pixValid),
    .pixReady (pixReady),
    .re       (re),
    .rAddr    (rAddr),
    .rd       (rd),
    .busy     (busy),
    .calcDone (calcDone),
    .curX     (curX),
    .curY     (curY)
  );

  always #5 wClk = ~wClk;

  int            checks = 0;
  int            passes = 0;
  logic [DW-1:0] model [PIX];
  logic [DW-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge wClk);
    #1;
  endtask

  // Issue one read, scoreboard its expected value, compare one cycle later.
  task automatic rd_chk(input string tag, input int addr);
    re    = 1'b1;
    rAddr = AW'(addr);
    exp_q.push_back(addr < PIX ? model[addr] : '0);
    step();
    re = 1'b0;
    check(tag, 32'(rd), 32'(exp_q.pop_front()));
  endtask

  initial begin
    int n;
    rstN = 1'b0; start = 1'b0; pixIn = '0; pixValid = 1'b0; re = 1'b0; rAddr = '0;
    step(); step();
    check("rst_ready", 32'(pixReady), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_done",  32'(calcDone), 0);
    check("rst_curx",  32'(curX), 0);
    check("rst_cury",  32'(curY), 0);
    check("rst_rd",    32'(rd), 0);
    rstN = 1'b1;
    step();

    // ---- frame A: valid held high, pixIn = addr[7:0]
    start = 1'b1;
    step();
    start = 1'b0;
    check("a_ready", 32'(pixReady), 1);
    check("a_busy",  32'(busy), 1);
    pixValid = 1'b1;
    for (int a = 0; a < PIX; a++) begin
      pixIn    = DW'(a);
      model[a] = DW'(a);
      step();
      if (a == 200) begin
        check("a_curx200", 32'(curX), 73);
        check("a_cury200", 32'(curY), 1);
      end
      if (a == PIX - 2) check("a_done_early", 32'(calcDone), 0);
    end
    check("a_done",    32'(calcDone), 1);
    check("a_busy_end", 32'(busy), 0);
    check("a_rdy_end", 32'(pixReady), 0);
    check("a_curx_end", 32'(curX), 0);
    check("a_cury_end", 32'(curY), 128);
    // pixValid in DONE must be ignored
    pixIn = 8'hFF;
    step(); step(); step();
    pixValid = 1'b0;
    check("done_ign_x", 32'(curX), 0);
    check("done_ign_y", 32'(curY), 128);
    check("done_ign_c", 32'(calcDone), 1);
    rd_chk("a_rd0", 0);
    re = 1'b1; rAddr = AW'(300); exp_q.push_back(8'h2C);
    step();
    re = 1'b0;
    check("a_rd300", 32'(rd), 32'(exp_q.pop_front()));
    rd_chk("a_rd16383", PIX - 1);
    rd_chk("a_rd_oor", PIX);
    rd_chk("a_rd300b", 300);
    rAddr = AW'(PIX);
    step(); step();
    check("rd_hold", 32'(rd), 8'h2C);

    // ---- frame B: pixValid toggles, start pulsed at pixel 5000
    start = 1'b1;
    step();
    start = 1'b0;
    check("b_done_drop", 32'(calcDone), 0);
    check("b_ready", 32'(pixReady), 1);
    n = 0;
    for (int c = 0; c < 2 * PIX + 4 && n < PIX; c++) begin
      pixValid = c[0];
      pixIn    = DW'(n) ^ 8'h5A;
      start    = (n == 5000) && c[0];
      if (c[0]) model[n] = DW'(n) ^ 8'h5A;
      step();
      if (c[0]) n++;
      check("b_curx", 32'(curX), 32'(n % W));
      check("b_cury", 32'(curY), 32'(n / W));
      check("b_done", 32'(calcDone), 32'(n == PIX));
    end
    pixValid = 1'b0;
    start    = 1'b0;
    rd_chk("b_rd300", 300);
    rd_chk("b_rd5000", 5000);
    rd_chk("b_rd127", 127);

    // ---- frame C: reset asserted after 100 pixels
    start = 1'b1;
    step();
    start    = 1'b0;
    pixValid = 1'b1;
    for (int a = 0; a < 100; a++) begin
      pixIn    = (a == 42) ? 8'h11 : ~DW'(a);
      model[a] = pixIn;
      step();
    end
    check("c_curx100", 32'(curX), 100);
    rstN = 1'b0;
    #1;
    check("c_rst_ready", 32'(pixReady), 0);
    check("c_rst_busy",  32'(busy), 0);
    check("c_rst_curx",  32'(curX), 0);
    check("c_rst_cury",  32'(curY), 0);
    check("c_rst_rd",    32'(rd), 0);
    step();
    rstN  = 1'b1;
    pixIn = 8'hEE;
    step(); step();
    pixValid = 1'b0;
    check("idle_ign_x", 32'(curX), 0);
    check("idle_ign_r", 32'(pixReady), 0);

    // ---- frame D: restart, collision at address 42
    start = 1'b1;
    step();
    start = 1'b0;
    check("d_ready", 32'(pixReady), 1);
    pixValid = 1'b1;
    for (int a = 0; a < 42; a++) begin
      pixIn    = DW'(a) ^ 8'h80;
      model[a] = pixIn;
      step();
    end
    pixIn = 8'hA5;
    re    = 1'b1;
    rAddr = AW'(42);
`ifdef IMG_WR_FWD_EN
    exp_q.push_back(8'hA5);
`else
    exp_q.push_back(8'h11);
`endif
    model[42] = 8'hA5;
    step();
    re       = 1'b0;
    pixValid = 1'b0;
    check("d_collide", 32'(rd), 32'(exp_q.pop_front()));
    check("d_curx", 32'(curX), 43);
    rd_chk("d_rd42", 42);
    rd_chk("d_rd50", 50);
    rd_chk("d_rd10", 10);
    rd_chk("d_rd0", 0);
    rd_chk("d_rd300", 300);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
